// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: opcodes, FSM states,
// and the command entry stored in the command FIFO.
package alu_pkg;

   localparam int unsigned ALU_W = 8;
   localparam int unsigned SEL_W = 3;

   localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
   localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
   localparam logic [SEL_W-1:0] OP_AND = 3'b010;
   localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
   localparam logic [SEL_W-1:0] OP_NOT = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic             use_acc;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and result signals of the ALU issue stage.
// master = producer/consumer/ALU side, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_sel;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_use_acc;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_sel;
   logic [WIDTH-1:0] alu_result;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [2:0]       res_sel;
   logic             busy;

   modport master (
      output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, alu_result, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, busy
   );

   modport slave (
      input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, alu_result, res_ready,
      output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, busy
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with registered count; rdata shows the head entry.
// Push when full and pop when empty are ignored.
module alu_cmd_fifo #(
   parameter int unsigned ENTRY_W = 8,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [ENTRY_W-1:0]             wdata,
   input  logic                           pop,
   output logic [ENTRY_W-1:0]             rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU: FIFO-buffered commands,
// registered ALU operands and a valid/ready result port.
// Optional accumulator forwarding of operand A under `ALU_ACC_FWD_EN.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_W,
   parameter int unsigned DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   alu_issue_ctrl_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   state_t           state;
   cmd_t             wr_entry;
   cmd_t             head;
   logic [CMD_W-1:0] rd_raw;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             pop_c;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [2:0]       alu_sel_q;
   logic [WIDTH-1:0] res_data_q;
   logic [2:0]       res_sel_q;
   logic             res_valid_q;

   always_comb begin
      wr_entry         = '0;
      wr_entry.sel     = bus.cmd_sel;
      wr_entry.a       = ALU_W'(bus.cmd_a);
      wr_entry.b       = ALU_W'(bus.cmd_b);
      wr_entry.use_acc = bus.cmd_use_acc;
   end

   assign head  = cmd_t'(rd_raw);
   assign pop_c = (state == IDLE) && !fifo_empty;

   alu_cmd_fifo #(
      .ENTRY_W (CMD_W),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cmd_valid),
      .wdata (CMD_W'(wr_entry)),
      .pop   (pop_c),
      .rdata (rd_raw),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef ALU_ACC_FWD_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] op_a_c;

   assign op_a_c = head.use_acc ? acc : WIDTH'(head.a);

   always_ff @(posedge clk) begin
      if (rst)                 acc <= '0;
      else if (state == EXEC)  acc <= bus.alu_result;
   end
`else
   logic [WIDTH-1:0] op_a_c;
   logic             unused_use_acc;

   assign op_a_c         = WIDTH'(head.a);
   assign unused_use_acc = head.use_acc;
`endif

   // Issue FSM: pop/load in IDLE, capture in EXEC, hold until accepted in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         res_data_q  <= '0;
         res_sel_q   <= '0;
         res_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  alu_a_q   <= op_a_c;
                  alu_b_q   <= WIDTH'(head.b);
                  alu_sel_q <= head.sel;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               res_data_q  <= bus.alu_result;
               res_sel_q   <= alu_sel_q;
               res_valid_q <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = !fifo_full;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_sel   = alu_sel_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_sel   = res_sel_q;
   assign bus.busy      = (state != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU on the alu_* side.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alu_issue_ctrl_if #(.WIDTH(8)) bus ();

   alu_issue_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: opcodes above OP_NOT fall back to add.
   always_comb begin
      case (bus.alu_sel)
         OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
         OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
         OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
         OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
         OP_NOT:  bus.alu_result = ~bus.alu_a;
         default: bus.alu_result = bus.alu_a + bus.alu_b;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One command into an idle stage with res_ready high; checks timing and result.
   task automatic run_one(input string tag, input logic [2:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic ua, input logic [7:0] exp);
      bus.res_ready   = 1'b1;
      bus.cmd_valid   = 1'b1;
      bus.cmd_sel     = sel;
      bus.cmd_a       = a;
      bus.cmd_b       = b;
      bus.cmd_use_acc = ua;
      step();
      bus.cmd_valid = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_noval_e0"}, 32'(bus.res_valid), 32'd0);
      step();
      check({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'(sel));
      check({tag, "_alu_b"}, 32'(bus.alu_b), 32'(b));
      check({tag, "_noval_e1"}, 32'(bus.res_valid), 32'd0);
      step();
      check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_data"}, 32'(bus.res_data), 32'(exp));
      check({tag, "_sel"}, 32'(bus.res_sel), 32'(sel));
      step();
      check({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_q [5];
      int accepted;
      int got;
      bit ok_now;
      bit seen_valid;
      logic [7:0] chain_exp;

      rst             = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_sel     = '0;
      bus.cmd_a       = '0;
      bus.cmd_b       = '0;
      bus.cmd_use_acc = 1'b0;
      bus.res_ready   = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
      check("rst_res_data", 32'(bus.res_data), 32'd0);
      check("rst_res_sel", 32'(bus.res_sel), 32'd0);

      run_one("add", 3'b000, 8'h3C, 8'h05, 1'b0, 8'h41);
      run_one("sub_wrap", 3'b001, 8'h05, 8'h06, 1'b0, 8'hFF);
      run_one("not", 3'b100, 8'hA5, 8'h00, 1'b0, 8'h5A);
      run_one("and", 3'b010, 8'hF0, 8'h3C, 1'b0, 8'h30);
      run_one("or", 3'b011, 8'hF0, 8'h0C, 1'b0, 8'hFC);
      run_one("op111", 3'b111, 8'h01, 8'h02, 1'b0, 8'h03);

      // Backpressure: one command in the FSM plus DEPTH buffered.
      bus.res_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 10; i++) begin
         ok_now = bus.cmd_ready;
         bus.cmd_valid   = 1'b1;
         bus.cmd_sel     = 3'b000;
         bus.cmd_a       = 8'(8'h10 * (accepted + 1));
         bus.cmd_b       = 8'h01;
         bus.cmd_use_acc = 1'b0;
         step();
         if (ok_now) accepted++;
      end
      bus.cmd_valid = 1'b0;
      exp_q = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h51};
      check("bp_accepted", 32'(accepted), 32'd5);
      check("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
      check("bp_valid_held", 32'(bus.res_valid), 32'd1);
      check("bp_res0", 32'(bus.res_data), 32'(exp_q[0]));
      bus.res_ready = 1'b1;
      step();
      check("bp_still_full", 32'(bus.cmd_ready), 32'd0);
      check("bp_valid_drop", 32'(bus.res_valid), 32'd0);
      step();
      check("bp_ready_after_pop", 32'(bus.cmd_ready), 32'd1);
      got = 1;
      for (int c = 0; c < 40 && got < 5; c++) begin
         if (bus.res_valid) begin
            check($sformatf("bp_res%0d", got), 32'(bus.res_data), 32'(exp_q[got]));
            got++;
         end
         step();
      end
      check("bp_count", 32'(got), 32'd5);
      step();
      check("bp_drained", 32'(bus.busy), 32'd0);

      // Reset while holding a result with three commands queued.
      bus.res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_sel   = 3'b000;
         bus.cmd_a     = 8'(8'h70 + i);
         bus.cmd_b     = 8'h01;
         step();
      end
      bus.cmd_valid = 1'b0;
      check("pre_rst_valid", 32'(bus.res_valid), 32'd1);
      check("pre_rst_data", 32'(bus.res_data), 32'h71);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
      check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
      check("mid_rst_alu_sel", 32'(bus.alu_sel), 32'd0);
      check("mid_rst_res_data", 32'(bus.res_data), 32'd0);
      check("mid_rst_res_sel", 32'(bus.res_sel), 32'd0);
      bus.res_ready = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.res_valid) seen_valid = 1'b1;
      end
      check("no_stale_result", 32'(seen_valid), 32'd0);
      check("post_rst_idle", 32'(bus.busy), 32'd0);

      // Accumulator chaining: second command asks for A from the last result.
`ifdef ALU_ACC_FWD_EN
      chain_exp = 8'h12;
`else
      chain_exp = 8'h01;
`endif
      run_one("chain0", 3'b000, 8'h10, 8'h01, 1'b0, 8'h11);
      run_one("chain1", 3'b000, 8'h00, 8'h01, 1'b1, chain_exp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-issue stage directly upstream of the 8-bit combinational ALU.
- Buffers operand/opcode commands in a small FIFO and drives the ALU `a`/`b`/`alu_sel` inputs from registers.
- Captures the ALU output one cycle after issue and presents it downstream on a valid/ready result port.
- Decouples the producer (decoder or testbench sequencer) from the result consumer.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU width.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept; high iff FIFO not full
- cmd_sel  input  3  ALU opcode
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- cmd_use_acc  input  1  replace A with last result; used only under ACC_FWD_EN, ignored otherwise
- alu_a  output  WIDTH  registered operand to ALU `a`
- alu_b  output  WIDTH  registered operand to ALU `b`
- alu_sel  output  3  registered opcode to ALU `alu_sel`
- alu_result  input  WIDTH  ALU `alu_out`
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  captured result
- res_sel  output  3  opcode that produced res_data
- busy  output  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset:
  - FIFO pointers and count = 0.
  - FSM = IDLE.
  - alu_a, alu_b, alu_sel, res_data, res_sel = 0.
  - res_valid = 0; busy = 0.
  - Accumulator = 0.
  - Any command or result in flight is discarded, with no partial output.
- Push: on a clock edge with cmd_valid & cmd_ready, write {cmd_sel, cmd_a, cmd_b, cmd_use_acc}.
- Full FIFO: cmd_ready = 0 even if a pop occurs in the same cycle; there is no full pass-through.
- Push and pop in the same cycle on a non-full FIFO: both occur; count is unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head at the edge, load alu_a/alu_b/alu_sel, go to EXEC. Otherwise stay.
  - EXEC: one cycle for the ALU to settle. At the edge, res_data <= alu_result, res_sel <= alu_sel, res_valid <= 1, accumulator <= alu_result, go to RESP.
  - RESP: hold res_data and res_sel stable. At an edge with res_ready = 1: res_valid <= 0, go to IDLE. Otherwise stay.
- Latency:
  - A command pushed into an empty FIFO at edge E0 is popped at E1 and captured at E2.
  - res_valid is high from E2.
  - Throughput is one result per 3 cycles when res_ready is held high.
- Backpressure: while in RESP the FSM does not pop; the FIFO continues accepting until full.
- Total commands acceptable with res_ready held low = DEPTH + 1 (one in the FSM, DEPTH buffered).
- Opcodes 101-111 are forwarded unchanged; the ALU default applies (add).
- alu_a/alu_b/alu_sel hold their last values in IDLE and RESP.
- Width: there is no carry/overflow output; results wrap modulo 2^WIDTH (done by the ALU).

Optional Feature:
- Macro ALU_ACC_FWD_EN.
- Defined: on pop with cmd_use_acc = 1, alu_a is loaded from the accumulator (the last captured result) instead of cmd_a. The accumulator is updated in EXEC of the same command before the next pop, so back-to-back chained commands see the newest result.
- Undefined: cmd_use_acc is ignored, alu_a is always cmd_a, and no accumulator register exists. The port remains present for a stable interface.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_NOT=3'b100
  - ALU_W = 8
  - FSM state encoding IDLE/EXEC/RESP
  - command-entry struct/width constant
- One sub-module: alu_cmd_fifo, a synchronous FIFO parameterised by entry width and DEPTH, with full/empty/count.
- The FSM and output registers stay in alu_issue_ctrl.

Test Plan:
- ADD, a=8'h3C, b=8'h05, res_ready=1 -> alu_sel=000; res_data=8'h41 and res_sel=000 two edges after accept; res_valid high for exactly 1 cycle.
- SUB, a=8'h05, b=8'h06 -> res_data=8'hFF (wrap). NOT, a=8'hA5 -> res_data=8'h5A. Opcode 3'b111, a=1, b=2 -> res_data=8'h03.
- res_ready=0, push continuously -> exactly 5 commands accepted, then cmd_ready=0. Raise res_ready -> five results in push order; cmd_ready returns high after the first pop.
- Assert rst while in RESP with 3 entries queued -> next cycle res_valid=0, busy=0, cmd_ready=1, all outputs 0; no stale result ever appears.
- ALU_ACC_FWD_EN: ADD 8'h10+8'h01, then ADD with use_acc=1, b=8'h01 -> results 8'h11 then 8'h12. Without the macro, the same stimulus with cmd_a=8'h00 -> 8'h11 then 8'h01.
